multicycle_control_unit: RTL and testbench

//  Moore-FSM controller for the multicycle MIPS datapath. It sequences fetch, decode, execute, memory and writeback over

---
 rtl/mips_ctrl_pkg.sv | 71 +++++++
 rtl/multicycle_control_unit_alu_decoder.sv | 45 ++++
 rtl/multicycle_control_unit.sv | 178 +++++++++++++++++
 tb/tb_multicycle_control_unit.sv | 274 +++++++++++++++++++++++++++
 4 files changed

// File: rtl/mips_ctrl_pkg.sv
// Shared encodings for the multicycle MIPS controller: opcodes, funct codes,
// ALU select codes, ALUOp classes and the controller state type.
package mips_ctrl_pkg;

   localparam logic [5:0] OP_R     = 6'b000000;
   localparam logic [5:0] OP_SHIFT = 6'b000001;
   localparam logic [5:0] OP_J     = 6'b000010;
   localparam logic [5:0] OP_JAL   = 6'b000011;
   localparam logic [5:0] OP_BEQ   = 6'b000100;
   localparam logic [5:0] OP_BNE   = 6'b000101;
   localparam logic [5:0] OP_ADDI  = 6'b001000;
   localparam logic [5:0] OP_ANDI  = 6'b001100;
   localparam logic [5:0] OP_ORI   = 6'b001101;
   localparam logic [5:0] OP_LW    = 6'b100011;
   localparam logic [5:0] OP_SW    = 6'b101011;

   localparam logic [5:0] FN_ADD = 6'b100000;
   localparam logic [5:0] FN_SUB = 6'b100010;
   localparam logic [5:0] FN_AND = 6'b100100;
   localparam logic [5:0] FN_OR  = 6'b100101;
   localparam logic [5:0] FN_SLT = 6'b101010;
   localparam logic [5:0] FN_SLL = 6'b000000;
   localparam logic [5:0] FN_SRL = 6'b000010;
   localparam logic [5:0] FN_SRA = 6'b000011;

   localparam logic [2:0] ALU_AND = 3'b000;
   localparam logic [2:0] ALU_OR  = 3'b001;
   localparam logic [2:0] ALU_ADD = 3'b010;
   localparam logic [2:0] ALU_SLL = 3'b011;
   localparam logic [2:0] ALU_SRL = 3'b100;
   localparam logic [2:0] ALU_SRA = 3'b101;
   localparam logic [2:0] ALU_SUB = 3'b110;
   localparam logic [2:0] ALU_SLT = 3'b111;

   localparam logic [1:0] ALUOP_ADD   = 2'b00;
   localparam logic [1:0] ALUOP_SUB   = 2'b01;
   localparam logic [1:0] ALUOP_FUNCT = 2'b10;
   localparam logic [1:0] ALUOP_LOGIC = 2'b11;

   typedef enum logic [3:0] {
      S_FETCH  = 4'd0,
      S_DECODE = 4'd1,
      S_EXEC_R = 4'd2,
      S_ALUWB  = 4'd3,
      S_MEMADR = 4'd4,
      S_MEMRD  = 4'd5,
      S_MEMWB  = 4'd6,
      S_MEMWR  = 4'd7,
      S_BRANCH = 4'd8,
      S_EXEC_I = 4'd9,
      S_IWB    = 4'd10,
      S_JUMP   = 4'd11,
      S_FAULT  = 4'd12
   } state_t;

   // Successor of DECODE; anything unrecognised is an illegal instruction.
   function automatic state_t decode_next(input logic [5:0] op);
      state_t s;
      s = S_FAULT;
      case (op)
         OP_R, OP_SHIFT:           s = S_EXEC_R;
         OP_LW, OP_SW:             s = S_MEMADR;
         OP_BEQ, OP_BNE:           s = S_BRANCH;
         OP_ADDI, OP_ANDI, OP_ORI: s = S_EXEC_I;
         OP_J, OP_JAL:             s = S_JUMP;
         default:                  s = S_FAULT;
      endcase
      return s;
   endfunction

endpackage

// File: rtl/multicycle_control_unit_alu_decoder.sv
// ALU select decoder: maps the controller's ALUOp class plus funct (R-type)
// or opcode (logical immediates) onto the ALU select code.
module alu_decoder
   import mips_ctrl_pkg::*;
#(
   parameter int OP_W     = 6,
   parameter int FUNCT_W  = 6,
   parameter int ALUSEL_W = 3
) (
   input  logic [1:0]          i_alu_op,
   input  logic [FUNCT_W-1:0]  i_funct,
   input  logic [OP_W-1:0]     i_opcode,
   output logic [ALUSEL_W-1:0] o_alu_sel
);

   always_comb begin
      o_alu_sel = ALU_ADD;
      case (i_alu_op)
         ALUOP_SUB: o_alu_sel = ALU_SUB;
         ALUOP_FUNCT: begin
            // Unknown funct codes fall back to add.
            case (i_funct)
               FN_ADD:  o_alu_sel = ALU_ADD;
               FN_SUB:  o_alu_sel = ALU_SUB;
               FN_AND:  o_alu_sel = ALU_AND;
               FN_OR:   o_alu_sel = ALU_OR;
               FN_SLT:  o_alu_sel = ALU_SLT;
               FN_SLL:  o_alu_sel = ALU_SLL;
               FN_SRL:  o_alu_sel = ALU_SRL;
               FN_SRA:  o_alu_sel = ALU_SRA;
               default: o_alu_sel = ALU_ADD;
            endcase
         end
         ALUOP_LOGIC: begin
            case (i_opcode)
               OP_ANDI: o_alu_sel = ALU_AND;
               OP_ORI:  o_alu_sel = ALU_OR;
               default: o_alu_sel = ALU_ADD;
            endcase
         end
         default: o_alu_sel = ALU_ADD;
      endcase
   end

endmodule

// File: rtl/multicycle_control_unit.sv
// Moore controller for the multicycle MIPS datapath: state register, memory
// wait timeout, sticky fault flag and the per-state select/strobe decode.
module multicycle_control_unit
   import mips_ctrl_pkg::*;
#(
   parameter int OP_W     = 6,
   parameter int FUNCT_W  = 6,
   parameter int ALUSEL_W = 3,
   parameter int TIMEOUT  = 16
) (
   input  logic                clk,
   input  logic                rst,
   input  logic [OP_W-1:0]     Opcode,
   input  logic [FUNCT_W-1:0]  funct,
   input  logic                zero,
   input  logic                mem_ready,
   output logic                mem_req,
   output logic                IorD,
   output logic                IRWE,
   output logic                DMWE,
   output logic                RFWE,
   output logic [1:0]          RFDSel,
   output logic [1:0]          WDSel,
   output logic                ALUSrcA,
   output logic [1:0]          ALUSrcB,
   output logic                ZeroExt,
   output logic                shamt_rsSel,
   output logic [1:0]          PCSrc,
   output logic                PCWE,
   output logic [ALUSEL_W-1:0] ALUSel,
   output logic                retire,
   output logic                fault,
   output logic [3:0]          o_dbg_state
);

   localparam int CNT_W = (TIMEOUT > 2) ? $clog2(TIMEOUT) : 1;
   localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(TIMEOUT - 1);

   state_t             r_state;
   logic [CNT_W-1:0]   r_wait_cnt;
   logic               r_fault;

   logic                w_mem_req, w_iord, w_irwe, w_dmwe, w_rfwe;
   logic [1:0]          w_rfdsel, w_wdsel, w_alusrcb, w_pcsrc, w_alu_op;
   logic                w_alusrca, w_zeroext, w_shamt, w_pcwe, w_retire, w_use_alu;
   logic [ALUSEL_W-1:0] w_dec_sel;
   logic                w_timeout;
   state_t              w_dec_next;

   // Memory handshake: a transfer completes in any cycle where mem_req and
   // mem_ready are both high; mem_req stays high until then, and mem_ready
   // seen while mem_req is low has no effect.
   assign w_timeout  = w_mem_req && !mem_ready && (r_wait_cnt == CNT_LAST);
   assign w_dec_next = decode_next(Opcode);

   alu_decoder #(
      .OP_W     (OP_W),
      .FUNCT_W  (FUNCT_W),
      .ALUSEL_W (ALUSEL_W)
   ) u_alu_dec (
      .i_alu_op  (w_alu_op),
      .i_funct   (funct),
      .i_opcode  (Opcode),
      .o_alu_sel (w_dec_sel)
   );

   always_ff @(posedge clk) begin
      if (rst) begin
         r_state    <= S_FETCH;
         r_wait_cnt <= '0;
         r_fault    <= 1'b0;
      end else begin
         if (w_mem_req && !mem_ready && !w_timeout) r_wait_cnt <= r_wait_cnt + 1'b1;
         else                                       r_wait_cnt <= '0;

         if (w_timeout) begin
            r_state <= S_FAULT;
            r_fault <= 1'b1;
         end else begin
            case (r_state)
               S_FETCH:  if (mem_ready) r_state <= S_DECODE;
               S_DECODE: begin
                  r_state <= w_dec_next;
                  if (w_dec_next == S_FAULT) r_fault <= 1'b1;
               end
               S_EXEC_R: r_state <= S_ALUWB;
               S_MEMADR: r_state <= (Opcode == OP_SW) ? S_MEMWR : S_MEMRD;
               S_MEMRD:  if (mem_ready) r_state <= S_MEMWB;
               S_MEMWR:  if (mem_ready) r_state <= S_FETCH;
               S_EXEC_I: r_state <= S_IWB;
               S_ALUWB, S_MEMWB, S_BRANCH, S_IWB, S_JUMP: r_state <= S_FETCH;
               S_FAULT:  r_state <= S_FAULT;
               default: begin
                  r_state <= S_FAULT;
                  r_fault <= 1'b1;
               end
            endcase
         end
      end
   end

   always_comb begin
      w_mem_req = 1'b0;  w_iord    = 1'b0;  w_irwe    = 1'b0;  w_dmwe  = 1'b0;
      w_rfwe    = 1'b0;  w_rfdsel  = 2'b00; w_wdsel   = 2'b00; w_alusrca = 1'b0;
      w_alusrcb = 2'b00; w_zeroext = 1'b0;  w_shamt   = 1'b0;  w_pcsrc = 2'b00;
      w_pcwe    = 1'b0;  w_retire  = 1'b0;  w_use_alu = 1'b0;  w_alu_op = ALUOP_ADD;
      case (r_state)
         S_FETCH: begin
            w_mem_req = 1'b1;  w_alusrcb = 2'b01; w_use_alu = 1'b1;
            w_irwe    = mem_ready;
            w_pcwe    = mem_ready;
         end
         S_DECODE: begin
            w_alusrcb = 2'b11; w_use_alu = 1'b1;
         end
         S_EXEC_R: begin
            w_alusrca = 1'b1;  w_use_alu = 1'b1;  w_alu_op = ALUOP_FUNCT;
            w_shamt   = (Opcode == OP_SHIFT);
         end
         S_ALUWB: begin
            w_rfwe = 1'b1; w_rfdsel = 2'b01; w_retire = 1'b1;
         end
         S_MEMADR: begin
            w_alusrca = 1'b1;  w_alusrcb = 2'b10; w_use_alu = 1'b1;
         end
         S_MEMRD: begin
            w_mem_req = 1'b1;  w_iord = 1'b1;
         end
         S_MEMWB: begin
            w_rfwe = 1'b1; w_wdsel = 2'b01; w_retire = 1'b1;
         end
         S_MEMWR: begin
            w_mem_req = 1'b1;  w_iord = 1'b1;  w_dmwe = 1'b1;
            w_retire  = mem_ready;
         end
         S_BRANCH: begin
            w_alusrca = 1'b1;  w_use_alu = 1'b1;  w_alu_op = ALUOP_SUB;
            w_pcsrc   = 2'b01; w_retire  = 1'b1;
            w_pcwe    = (Opcode == OP_BNE) ? !zero : zero;
         end
         S_EXEC_I: begin
            w_alusrca = 1'b1;  w_alusrcb = 2'b10; w_use_alu = 1'b1;
            w_alu_op  = ALUOP_LOGIC;
            w_zeroext = (Opcode == OP_ANDI) || (Opcode == OP_ORI);
         end
         S_IWB: begin
            w_rfwe = 1'b1; w_retire = 1'b1;
         end
         S_JUMP: begin
            // jal links PC, which FETCH already advanced by 4.
            w_pcsrc = 2'b10; w_pcwe = 1'b1; w_retire = 1'b1;
            if (Opcode == OP_JAL) begin
               w_rfwe = 1'b1; w_rfdsel = 2'b10; w_wdsel = 2'b10;
            end
         end
         default: ;
      endcase
   end

   assign mem_req     = w_mem_req & ~rst;
   assign IorD        = w_iord & ~rst;
   assign IRWE        = w_irwe & ~rst;
   assign DMWE        = w_dmwe & ~rst;
   assign RFWE        = w_rfwe & ~rst;
   assign RFDSel      = rst ? 2'b00 : w_rfdsel;
   assign WDSel       = rst ? 2'b00 : w_wdsel;
   assign ALUSrcA     = w_alusrca & ~rst;
   assign ALUSrcB     = rst ? 2'b00 : w_alusrcb;
   assign ZeroExt     = w_zeroext & ~rst;
   assign shamt_rsSel = w_shamt & ~rst;
   assign PCSrc       = rst ? 2'b00 : w_pcsrc;
   assign PCWE        = w_pcwe & ~rst;
   assign ALUSel      = (rst || !w_use_alu) ? '0 : w_dec_sel;
   assign retire      = w_retire & ~rst;
   assign fault       = r_fault & ~rst;
   assign o_dbg_state = r_state;

endmodule

// File: tb/tb_multicycle_control_unit.sv
// Bench for multicycle_control_unit: an instruction-level model expands each
// instruction into its expected per-cycle control vectors, compared every cycle.
module tb_multicycle_control_unit;

   localparam int TMO = 16;

   typedef struct packed {
      logic       mem_req;
      logic       IorD;
      logic       IRWE;
      logic       DMWE;
      logic       RFWE;
      logic [1:0] RFDSel;
      logic [1:0] WDSel;
      logic       ALUSrcA;
      logic [1:0] ALUSrcB;
      logic       ZeroExt;
      logic       shamt_rsSel;
      logic [1:0] PCSrc;
      logic       PCWE;
      logic [2:0] ALUSel;
      logic       retire;
      logic       fault;
   } ctl_t;

   localparam logic [5:0] R_OP = 6'b000000, SH_OP = 6'b000001, J_OP = 6'b000010, JAL_OP = 6'b000011;
   localparam logic [5:0] BEQ_OP = 6'b000100, BNE_OP = 6'b000101, ADDI_OP = 6'b001000;
   localparam logic [5:0] ANDI_OP = 6'b001100, ORI_OP = 6'b001101, LW_OP = 6'b100011, SW_OP = 6'b101011;

   logic clk = 1'b0;
   always #5 clk = ~clk;

   logic       rst, zero, mem_ready;
   logic [5:0] Opcode, funct;
   logic       mem_req, IorD, IRWE, DMWE, RFWE, ALUSrcA, ZeroExt, shamt_rsSel, PCWE, retire, fault;
   logic [1:0] RFDSel, WDSel, ALUSrcB, PCSrc;
   logic [2:0] ALUSel;
   logic [3:0] dbg_state;

   multicycle_control_unit dut (
      .clk(clk), .rst(rst), .Opcode(Opcode), .funct(funct), .zero(zero), .mem_ready(mem_ready),
      .mem_req(mem_req), .IorD(IorD), .IRWE(IRWE), .DMWE(DMWE), .RFWE(RFWE), .RFDSel(RFDSel),
      .WDSel(WDSel), .ALUSrcA(ALUSrcA), .ALUSrcB(ALUSrcB), .ZeroExt(ZeroExt),
      .shamt_rsSel(shamt_rsSel), .PCSrc(PCSrc), .PCWE(PCWE), .ALUSel(ALUSel),
      .retire(retire), .fault(fault), .o_dbg_state(dbg_state)
   );

   ctl_t act;
   assign act = {mem_req, IorD, IRWE, DMWE, RFWE, RFDSel, WDSel, ALUSrcA, ALUSrcB,
                 ZeroExt, shamt_rsSel, PCSrc, PCWE, ALUSel, retire, fault};

   logic [21:0] exp_q[$];
   int n_total = 0, n_bad = 0, drv_cyc = 0, smp_cyc = 0, last_retire = -1, n_retire = 0;

   logic [5:0] ops [0:10] = '{R_OP, SH_OP, J_OP, JAL_OP, BEQ_OP, BNE_OP, ADDI_OP, ANDI_OP, ORI_OP, LW_OP, SW_OP};
   logic [5:0] fns [0:7]  = '{6'b100000, 6'b100010, 6'b100100, 6'b100101, 6'b101010, 6'b000000, 6'b000010, 6'b000011};

   task automatic check(input string name, input logic [31:0] a, input logic [31:0] e);
      n_total++;
      if (a !== e) begin
         n_bad++;
         $display("FAIL %s cyc=%0d actual=%h expected=%h", name, smp_cyc, a, e);
      end
   endtask

   // Scoreboard: one expected control vector per driven cycle.
   always @(negedge clk) begin
      if (exp_q.size() > 0) begin
         check("ctl", 32'(act), 32'(exp_q.pop_front()));
         if (retire === 1'b1) begin
            n_retire++;
            last_retire = smp_cyc;
         end
         smp_cyc++;
      end
   end

   function automatic logic rb();
      return 1'($urandom_range(0, 1));
   endfunction

   function automatic logic [5:0] r6();
      return 6'($urandom_range(0, 63));
   endfunction

   function automatic logic [2:0] r_sel(input logic [5:0] fn);
      case (fn)
         6'b100000: return 3'b010;
         6'b100010: return 3'b110;
         6'b100100: return 3'b000;
         6'b100101: return 3'b001;
         6'b101010: return 3'b111;
         6'b000000: return 3'b011;
         6'b000010: return 3'b100;
         6'b000011: return 3'b101;
         default:   return 3'b010;
      endcase
   endfunction

   task automatic cyc(input logic rdy, input logic z, input logic r, input logic [5:0] op,
                      input logic [5:0] fn, input ctl_t e);
      @(posedge clk);
      #1;
      rst = r; mem_ready = rdy; zero = z; Opcode = op; funct = fn;
      exp_q.push_back(e);
      drv_cyc++;
   endtask

   task automatic mem_phase(input ctl_t e_wait, input ctl_t e_rdy, input int waits, input logic z,
                            input logic [5:0] op, input logic [5:0] fn, input bit rnd_op,
                            output bit timed_out);
      timed_out = 1'b0;
      for (int i = 0; i < waits && i < TMO; i++)
         cyc(1'b0, z, 1'b0, rnd_op ? r6() : op, rnd_op ? r6() : fn, e_wait);
      if (waits >= TMO) timed_out = 1'b1;
      else cyc(1'b1, z, 1'b0, rnd_op ? r6() : op, rnd_op ? r6() : fn, e_rdy);
   endtask

   task automatic fault_hold(input int n);
      ctl_t e;
      e = '0;
      e.fault = 1'b1;
      repeat (n) cyc(rb(), rb(), 1'b0, r6(), r6(), e);
   endtask

   task automatic do_reset(input int n);
      ctl_t e;
      e = '0;
      repeat (n) cyc(1'b1, rb(), 1'b1, r6(), r6(), e);
   endtask

   // Expands one instruction into its expected cycles; fw/mw are the number of
   // cycles mem_ready stays low in the fetch and data-memory phases.
   task automatic run_instr(input logic [5:0] op, input logic [5:0] fn, input int fw, input int mw,
                            input logic z, output bit faulted);
      ctl_t e, e2;
      bit to;
      faulted = 1'b0;
      e = '0; e.mem_req = 1'b1; e.ALUSrcB = 2'b01; e.ALUSel = 3'b010;
      e2 = e; e2.IRWE = 1'b1; e2.PCWE = 1'b1;
      mem_phase(e, e2, fw, z, op, fn, 1'b1, to);
      if (to) begin faulted = 1'b1; return; end
      e = '0; e.ALUSrcB = 2'b11; e.ALUSel = 3'b010;
      cyc(rb(), z, 1'b0, op, fn, e);
      case (op)
         R_OP, SH_OP: begin
            e = '0; e.ALUSrcA = 1'b1; e.shamt_rsSel = (op == SH_OP); e.ALUSel = r_sel(fn);
            cyc(rb(), z, 1'b0, op, fn, e);
            e = '0; e.RFWE = 1'b1; e.RFDSel = 2'b01; e.retire = 1'b1;
            cyc(rb(), z, 1'b0, op, fn, e);
         end
         LW_OP, SW_OP: begin
            e = '0; e.ALUSrcA = 1'b1; e.ALUSrcB = 2'b10; e.ALUSel = 3'b010;
            cyc(rb(), z, 1'b0, op, fn, e);
            e = '0; e.mem_req = 1'b1; e.IorD = 1'b1; e.DMWE = (op == SW_OP);
            e2 = e; e2.retire = (op == SW_OP);
            mem_phase(e, e2, mw, z, op, fn, 1'b0, to);
            if (to) begin faulted = 1'b1; return; end
            if (op == LW_OP) begin
               e = '0; e.RFWE = 1'b1; e.WDSel = 2'b01; e.retire = 1'b1;
               cyc(rb(), z, 1'b0, op, fn, e);
            end
         end
         BEQ_OP, BNE_OP: begin
            e = '0; e.ALUSrcA = 1'b1; e.ALUSel = 3'b110; e.PCSrc = 2'b01; e.retire = 1'b1;
            e.PCWE = (op == BNE_OP) ? !z : z;
            cyc(rb(), z, 1'b0, op, fn, e);
         end
         ADDI_OP, ANDI_OP, ORI_OP: begin
            e = '0; e.ALUSrcA = 1'b1; e.ALUSrcB = 2'b10; e.ZeroExt = (op != ADDI_OP);
            e.ALUSel = (op == ANDI_OP) ? 3'b000 : (op == ORI_OP) ? 3'b001 : 3'b010;
            cyc(rb(), z, 1'b0, op, fn, e);
            e = '0; e.RFWE = 1'b1; e.retire = 1'b1;
            cyc(rb(), z, 1'b0, op, fn, e);
         end
         J_OP, JAL_OP: begin
            e = '0; e.PCSrc = 2'b10; e.PCWE = 1'b1; e.retire = 1'b1;
            if (op == JAL_OP) begin e.RFWE = 1'b1; e.RFDSel = 2'b10; e.WDSel = 2'b10; end
            cyc(rb(), z, 1'b0, op, fn, e);
         end
         default: faulted = 1'b1;
      endcase
   endtask

   // Single instruction with literal latency (FETCH to retire inclusive).
   task automatic directed(input string name, input logic [5:0] op, input logic [5:0] fn,
                           input int fw, input int mw, input logic z, input int exp_lat);
      int s, r0;
      bit f;
      s = drv_cyc;
      r0 = n_retire;
      run_instr(op, fn, fw, mw, z, f);
      @(negedge clk);
      #1;
      check({name, "_latency"}, 32'(last_retire - s + 1), 32'(exp_lat));
      check({name, "_retires"}, 32'(n_retire - r0), 32'd1);
   endtask

   initial begin
      ctl_t e;
      bit f;
      logic [5:0] op, fn;
      int fw, mw;
      rst = 1'b1; mem_ready = 1'b0; zero = 1'b0; Opcode = '0; funct = '0;
      do_reset(2);

      directed("add", R_OP, 6'b100000, 0, 0, rb(), 4);
      directed("sub_fw2", R_OP, 6'b100010, 2, 0, rb(), 6);
      directed("sll", SH_OP, 6'b000000, 0, 0, rb(), 4);
      directed("lw_mw3", LW_OP, r6(), 0, 3, rb(), 8);
      directed("sw", SW_OP, r6(), 0, 0, rb(), 4);
      directed("beq_z1", BEQ_OP, r6(), 0, 0, 1'b1, 3);
      directed("bne_z1", BNE_OP, r6(), 0, 0, 1'b1, 3);
      directed("bne_z0", BNE_OP, r6(), 0, 0, 1'b0, 3);
      directed("jal", JAL_OP, r6(), 0, 0, rb(), 3);
      directed("ori", ORI_OP, r6(), 0, 0, rb(), 4);
      directed("fetch_wait15", ADDI_OP, r6(), 15, 0, rb(), 19);

      // Fetch timeout, fault stickiness, recovery only through reset.
      run_instr(ADDI_OP, r6(), 16, 0, rb(), f);
      fault_hold(10);
      @(negedge clk); #1;
      check("fault_sticky", 32'(fault), 32'd1);
      do_reset(1);
      directed("after_fault", ANDI_OP, r6(), 0, 0, rb(), 4);

      // Data read timeout.
      run_instr(LW_OP, r6(), 0, 16, rb(), f);
      fault_hold(4);
      do_reset(1);

      // Illegal opcode.
      run_instr(6'b111111, r6(), 0, 0, rb(), f);
      fault_hold(6);
      @(negedge clk); #1;
      check("illegal_fault", 32'(fault), 32'd1);
      do_reset(1);
      @(negedge clk); #1;
      check("reset_fault", 32'(fault), 32'd0);

      // Reset while a store waits: no write strobe in the reset cycle, counter cleared.
      e = '0; e.mem_req = 1'b1; e.ALUSrcB = 2'b01; e.ALUSel = 3'b010; e.IRWE = 1'b1; e.PCWE = 1'b1;
      cyc(1'b1, 1'b0, 1'b0, r6(), r6(), e);
      e = '0; e.ALUSrcB = 2'b11; e.ALUSel = 3'b010;
      cyc(1'b0, 1'b0, 1'b0, SW_OP, 6'd0, e);
      e = '0; e.ALUSrcA = 1'b1; e.ALUSrcB = 2'b10; e.ALUSel = 3'b010;
      cyc(1'b0, 1'b0, 1'b0, SW_OP, 6'd0, e);
      e = '0; e.mem_req = 1'b1; e.IorD = 1'b1; e.DMWE = 1'b1;
      repeat (3) cyc(1'b0, 1'b0, 1'b0, SW_OP, 6'd0, e);
      do_reset(1);
      directed("rst_mid_sw", ORI_OP, r6(), 15, 0, rb(), 19);

      for (int k = 0; k < 300; k++) begin
         op = ops[$urandom_range(0, 10)];
         fn = ($urandom_range(0, 4) == 0) ? r6() : fns[$urandom_range(0, 7)];
         fw = ($urandom_range(0, 19) == 0) ? 15 : int'($urandom_range(0, 3));
         mw = ($urandom_range(0, 19) == 0) ? 15 : int'($urandom_range(0, 3));
         if ($urandom_range(0, 59) == 0) fw = TMO;
         if ($urandom_range(0, 59) == 0) mw = TMO;
         if ($urandom_range(0, 59) == 0) op = ($urandom_range(0, 1) == 0) ? 6'b111111 : 6'b010000;
         run_instr(op, fn, fw, mw, rb(), f);
         if (f) begin
            fault_hold(int'($urandom_range(1, 4)));
            do_reset(int'($urandom_range(1, 2)));
         end
      end

      @(negedge clk); #1;
      check("queue_drained", 32'(exp_q.size()), 32'd0);
      $display("test done: total=%0d bad=%0d", n_total, n_bad);
      $finish;
   end

endmodule
